// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   DEFAULT_WIDTH / DEFAULT_CNT_W : default operand and counter widths
//   OP_*                          : 3-bit ALU opcodes
//   state_e                       : arbiter FSM state encoding
package alu_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = 16;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/result bus between two requesters + one consumer and the ALU arbiter.
//   req_valid[1:0], req_ready[1:0] : per-requester handshake (bit i = requester i)
//   req_op0/1, req_a0/1, req_b0/1  : opcode and operands per requester
//   res_valid, res_ready           : result handshake
//   res_data, res_id, res_zero, res_carry : result payload
// master = requesters/consumer side, slave = arbiter side.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req_op0;
    logic [2:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_zero;
    logic             res_carry;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_zero, res_carry
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, res_ready,
        output req_ready, res_valid, res_data, res_id, res_zero, res_carry
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU used by the arbiter.
//   a, b  : operands
//   op    : opcode (OP_* from alu_arbiter_pkg)
//   y     : result
//   carry : ADD carry-out, SUB no-borrow flag, 0 otherwise
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    // One extra bit captures carry-out / borrow.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_ADD: begin
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                y     = diff[WIDTH-1:0];
                carry = ~diff[WIDTH];  // top bit set means a borrow occurred
            end
            OP_SLT:  y = WIDTH'($signed(a) < $signed(b));
            OP_NOR:  y = ~(a | b);
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter: grants one request at a time (alternating priority
// when both are pending), computes the result in the following cycle and holds it
// until the consumer accepts it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_arbiter_if slave (request and result handshakes)
//   busy       : high while a transaction is in EXEC or DONE
//   op_count   : number of results consumed since reset (wraps)
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q;
    logic             ptr_q;       // requester favoured on a tie
    logic             id_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;
    logic             res_zero_q;
    logic             res_carry_q;
    logic [CNT_W-1:0] op_count_q;

    logic [1:0]       grant;
    logic             sel;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry;

    // Grant is combinational so the requester sees req_ready in the accept cycle.
    // Gated by rst_n so req_ready drops immediately when reset asserts.
    always_comb begin
        grant = 2'b00;
        if (rst_n && (state_q == StIdle)) begin
            unique case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel = grant[1];

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .y    (alu_y),
        .carry(alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_zero_q  <= 1'b0;
            res_carry_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant != 2'b00) begin
                        id_q    <= sel;
                        op_q    <= sel ? bus.req_op1 : bus.req_op0;
                        a_q     <= sel ? bus.req_a1  : bus.req_a0;
                        b_q     <= sel ? bus.req_b1  : bus.req_b0;
                        ptr_q   <= ~sel;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    res_data_q  <= alu_y;
                    res_zero_q  <= (alu_y == '0);
                    res_carry_q <= alu_carry;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_carry = res_carry_q;
    assign busy          = (state_q != StIdle);
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(
        .WIDTH(32),
        .CNT_W(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .op_count(op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        id;
        logic        zero;
        logic        carry;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic        m_busy = 1'b0;
    logic        m_ptr = 1'b0;
    logic [15:0] m_count = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic id, input int acc);
        exp_t        e;
        logic [32:0] s;
        e.id    = id;
        e.acc   = acc;
        e.carry = 1'b0;
        e.data  = '0;
        case (op)
            3'd0: e.data = a & b;
            3'd1: e.data = a | b;
            3'd2: e.data = a ^ b;
            3'd3: begin
                s       = {1'b0, a} + {1'b0, b};
                e.data  = s[31:0];
                e.carry = s[32];
            end
            3'd4: begin
                e.data  = a - b;
                e.carry = (a >= b);
            end
            3'd5: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: e.data = ~(a | b);
            default: e.data = a;
        endcase
        e.zero = (e.data == 32'd0);
        return e;
    endfunction

    // Monitor/scoreboard: predicts grants, pushes expected results on accept,
    // compares the result bus every cycle it is due, pops on handshake.
    always @(negedge clk) begin
        logic [1:0] eg;
        if (!rst_n) begin
            sb.delete();
            m_busy  = 1'b0;
            m_ptr   = 1'b0;
            m_count = '0;
        end else begin
            check("op_count", op_count, m_count);
            if (!m_busy) begin
                eg = 2'b00;
                case (bus.req_valid)
                    2'b01: eg = 2'b01;
                    2'b10: eg = 2'b10;
                    2'b11: eg = m_ptr ? 2'b10 : 2'b01;
                    default: eg = 2'b00;
                endcase
                check("req_ready", bus.req_ready, eg);
                check("busy_idle", busy, 0);
                if (eg != 2'b00) begin
                    if (eg[1]) sb.push_back(model(bus.req_op1, bus.req_a1, bus.req_b1, 1'b1, cyc));
                    else       sb.push_back(model(bus.req_op0, bus.req_a0, bus.req_b0, 1'b0, cyc));
                    m_ptr  = ~eg[1];
                    m_busy = 1'b1;
                end
            end else begin
                check("req_ready_busy", bus.req_ready, 0);
                check("busy", busy, 1);
            end
            if (sb.size() == 0) begin
                check("res_valid_idle", bus.res_valid, 0);
            end else if (cyc < sb[0].acc + 2) begin
                check("res_valid_early", bus.res_valid, 0);
            end else begin
                check("res_valid", bus.res_valid, 1);
                check("res_data", bus.res_data, sb[0].data);
                check("res_id", bus.res_id, sb[0].id);
                check("res_zero", bus.res_zero, sb[0].zero);
                check("res_carry", bus.res_carry, sb[0].carry);
                if (bus.res_valid && bus.res_ready) begin
                    void'(sb.pop_front());
                    m_count = m_count + 16'd1;
                    m_busy  = 1'b0;
                end
            end
        end
    end

    // Holds the requested valid bits until each is accepted; accepted requesters
    // then scramble their inputs to prove the in-flight result is unaffected.
    task automatic run_req(input logic [1:0] valid,
                           input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                           input bit first_only);
        logic [1:0] pend;
        logic [1:0] acc;
        pend = valid;
        @(posedge clk) #1;
        bus.req_op0 = op0; bus.req_a0 = a0; bus.req_b0 = b0;
        bus.req_op1 = op1; bus.req_a1 = a1; bus.req_b1 = b1;
        bus.req_valid = pend;
        for (int i = 0; i < 200 && pend != 2'b00; i++) begin
            @(negedge clk);
            acc = bus.req_ready & pend;
            @(posedge clk) #1;
            if (acc != 2'b00) begin
                pend = first_only ? 2'b00 : (pend & ~acc);
                if (acc[0]) begin
                    bus.req_op0 = 3'($urandom); bus.req_a0 = $urandom; bus.req_b0 = $urandom;
                end
                if (acc[1]) begin
                    bus.req_op1 = 3'($urandom); bus.req_a1 = $urandom; bus.req_b1 = $urandom;
                end
            end
            bus.req_valid = pend;
        end
        check("req_accept_timeout", pend, 0);
        bus.req_valid = 2'b00;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.res_valid && !busy) done = 1'b1;
        end
        check("drain_timeout", done, 1);
        @(posedge clk) #1;
    endtask

    // Asserts reset mid-cycle with both requests pending and checks outputs at once.
    task automatic reset_check();
        bus.req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_id", bus.res_id, 0);
        check("rst_res_zero", bus.res_zero, 0);
        check("rst_res_carry", bus.res_carry, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        check("rst_req_ready", bus.req_ready, 0);
        repeat (2) @(posedge clk);
        #3;
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.req_op0 = '0; bus.req_a0 = '0; bus.req_b0 = '0;
        bus.req_op1 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Both valid from reset: req0 first, then req1; repeated tie goes to req0.
        run_req(2'b11, 3'd3, 32'd1, 32'd2, 3'd1, 32'd1, 32'd2, 1'b0);
        wait_drain();
        run_req(2'b11, 3'd3, 32'd1, 32'd2, 3'd1, 32'd1, 32'd2, 1'b1);
        wait_drain();
        check("op_count_three", op_count, 3);

        run_req(2'b01, 3'd1, 32'hFFFF0000, 32'h0000FFFF, 3'd0, 32'd0, 32'd0, 1'b0);
        wait_drain();

        run_req(2'b01, 3'd3, 32'hFFFFFFFF, 32'd1, 3'd0, 32'd0, 32'd0, 1'b0);
        run_req(2'b10, 3'd0, 32'd0, 32'd0, 3'd4, 32'd5, 32'd7, 1'b0);
        run_req(2'b01, 3'd5, 32'h80000000, 32'd1, 3'd0, 32'd0, 32'd0, 1'b0);
        run_req(2'b10, 3'd0, 32'd0, 32'd0, 3'd5, 32'd1, 32'h80000000, 1'b0);
        run_req(2'b01, 3'd4, 32'd9, 32'd9, 3'd0, 32'd0, 32'd0, 1'b0);
        run_req(2'b10, 3'd0, 32'd0, 32'd0, 3'd6, 32'h0F0F0000, 32'h000000F0, 1'b0);
        wait_drain();

        // Backpressure: both pending while the result is held for several cycles.
        bus.res_ready = 1'b0;
        fork
            run_req(2'b11, 3'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'd7, 32'h12345678, 32'd0, 1'b0);
            begin
                repeat (7) @(posedge clk);
                #2;
                check("bp_busy", busy, 1);
                check("bp_res_valid", bus.res_valid, 1);
                bus.res_ready = 1'b1;
            end
        join
        wait_drain();

        // Randomised traffic with random result backpressure.
        for (int n = 0; n < 24; n++) begin
            bus.res_ready = 1'($urandom);
            fork
                run_req(2'($urandom_range(1, 3)), 3'($urandom), $urandom, $urandom,
                        3'($urandom), $urandom, $urandom, 1'($urandom));
                begin
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #2;
                    bus.res_ready = 1'b1;
                end
            join
            wait_drain();
        end

        // Reset during EXEC discards the transaction and restores priority to req0.
        run_req(2'b10, 3'd3, 32'd0, 32'd0, 3'd3, 32'd4, 32'd4, 1'b1);
        reset_check();
        repeat (5) @(posedge clk);
        #1;
        check("op_count_after_rst", op_count, 0);
        run_req(2'b11, 3'd7, 32'd11, 32'd0, 3'd7, 32'd22, 32'd0, 1'b1);
        wait_drain();

        // Reset mid-cycle while holding a result in DONE.
        bus.res_ready = 1'b0;
        run_req(2'b01, 3'd3, 32'd40, 32'd2, 3'd0, 32'd0, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        check("done_res_valid", bus.res_valid, 1);
        reset_check();
        bus.res_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("op_count_final", op_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
